// File: rtl/ldpc_enc_ctrl.sv
// Frame controller for the LDPC encoder: info intake, parity stepping/drain, codeword readout.
// Optional short-frame abort is compiled in with `define LDPC_ENC_FRAME_ERR_EN.
module ldpc_enc_ctrl #(
  parameter int unsigned PAR_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rate,
  input  logic        sync_in,
  input  logic        din_vld,
  input  logic        dout_rdy,
  output logic [3:0]  fsm_state,
  output logic        din_rdy,
  output logic [12:0] wr_addr,
  output logic        par_en,
  output logic [8:0]  par_addr,
  output logic        dout_vld,
  output logic [13:0] rd_addr,
  output logic        dout_sel,
  output logic        sync_out,
  output logic        busy,
  output logic        frame_err
);

  // One-hot encoding doubles as the fsm_state output.
  typedef enum logic [3:0] {
    StIdle    = 4'b0001,
    StDataIn  = 4'b0010,
    StParity  = 4'b0100,
    StDataOut = 4'b1000
  } state_e;

  localparam logic [13:0] CwLast  = 14'd9215;
  localparam logic [3:0]  LatLast = 4'(PAR_LAT - 1);

  state_e      state_q, state_d;
  logic        rate_q, rate_d;
  logic [12:0] wr_addr_q, wr_addr_d;
  logic [8:0]  par_addr_q, par_addr_d;
  logic        drain_q, drain_d;
  logic [3:0]  lat_q, lat_d;
  logic [13:0] rd_addr_q, rd_addr_d;
  logic        frame_err_q, frame_err_d;

  logic [12:0] info_last;
  logic [8:0]  steps_last;
  logic [13:0] info_len;

  always_comb begin
    info_last  = rate_q ? 13'd6911 : 13'd4607;
    steps_last = rate_q ? 9'd143 : 9'd287;
    info_len   = rate_q ? 14'd6912 : 14'd4608;
  end

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    wr_addr_d   = wr_addr_q;
    par_addr_d  = par_addr_q;
    drain_d     = drain_q;
    lat_d       = lat_q;
    rd_addr_d   = rd_addr_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sync_in) begin
          state_d = StDataIn;
          rate_d  = rate;
        end
      end
      StDataIn: begin
        if (din_vld) begin
          if (wr_addr_q == info_last) state_d = StParity;
          else                        wr_addr_d = wr_addr_q + 13'd1;
        end
`ifdef LDPC_ENC_FRAME_ERR_EN
        if (!sync_in && !(din_vld && (wr_addr_q == info_last))) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
          rate_d      = 1'b0;
          wr_addr_d   = '0;
        end
`endif
      end
      StParity: begin
        if (!drain_q) begin
          if (par_addr_q == steps_last) begin
            drain_d = 1'b1;
            lat_d   = '0;
          end else begin
            par_addr_d = par_addr_q + 9'd1;
          end
        end else if (lat_q == LatLast) begin
          state_d = StDataOut;
          drain_d = 1'b0;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StDataOut: begin
        if (dout_rdy) begin
          if (rd_addr_q == CwLast) begin
            state_d    = StIdle;
            rate_d     = 1'b0;
            wr_addr_d  = '0;
            par_addr_d = '0;
            rd_addr_d  = '0;
          end else begin
            rd_addr_d = rd_addr_q + 14'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rate_q      <= 1'b0;
      wr_addr_q   <= '0;
      par_addr_q  <= '0;
      drain_q     <= 1'b0;
      lat_q       <= '0;
      rd_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      wr_addr_q   <= wr_addr_d;
      par_addr_q  <= par_addr_d;
      drain_q     <= drain_d;
      lat_q       <= lat_d;
      rd_addr_q   <= rd_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign fsm_state = state_q;
  assign din_rdy   = (state_q == StDataIn);
  assign wr_addr   = wr_addr_q;
  assign par_en    = (state_q == StParity) && !drain_q;
  assign par_addr  = par_addr_q;
  assign dout_vld  = (state_q == StDataOut);
  assign sync_out  = (state_q == StDataOut);
  assign rd_addr   = rd_addr_q;
  assign dout_sel  = (state_q == StDataOut) && (rd_addr_q >= info_len);
  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;

endmodule
